// File: rtl/vga_sync_decoder_if.sv
// Pixel-stream bundle between a VGA timing source and vga_sync_decoder.
// The source drives sync, blank and colour; the decoder returns coordinates and lock status.
interface vga_sync_decoder_if;
  logic       iHS;
  logic       iVS;
  logic       iBLANK;
  logic [9:0] iRed;
  logic [9:0] iGreen;
  logic [9:0] iBlue;
  logic [9:0] oX;
  logic [9:0] oY;
  logic [9:0] oRed;
  logic [9:0] oGreen;
  logic [9:0] oBlue;
  logic       oValid;
  logic       oLocked;
  logic       oErr;
  logic [9:0] oLineLen;
  logic [9:0] oFrameLines;

  modport master (
    output iHS, iVS, iBLANK, iRed, iGreen, iBlue,
    input  oX, oY, oRed, oGreen, oBlue, oValid, oLocked, oErr, oLineLen, oFrameLines
  );

  modport slave (
    input  iHS, iVS, iBLANK, iRed, iGreen, iBlue,
    output oX, oY, oRed, oGreen, oBlue, oValid, oLocked, oErr, oLineLen, oFrameLines
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from HS/VS/BLANK and declares lock once line and
// frame periods have matched H_TOTAL/V_TOTAL for LOCK_FRAMES frames in a row.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX   = 10'h3FF;
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [2:0]  LOCK_W    = 3'(LOCK_FRAMES);

  logic        r_hs_d, r_vs_d;
  logic [9:0]  r_line_cnt, r_x, r_y, r_fl_cnt;
  logic [9:0]  r_ox, r_oy, r_red, r_green, r_blue, r_line_len, r_frame_lines;
  logic        r_blank;
  state_t      r_state, w_state_next;
  logic [2:0]  r_good, w_good_next;
  logic        r_line_err, w_line_err_next;
  logic        r_err, w_err_next;

  logic        w_hs_edge, w_vs_edge, w_line_sat, w_period_bad, w_frame_bad;
  logic [10:0] w_line_period;

  assign w_hs_edge     = r_hs_d & ~bus.iHS;
  assign w_vs_edge     = r_vs_d & ~bus.iVS;
  assign w_line_period = {1'b0, r_line_cnt} + 11'd1;
  // Fires on the cycle the line counter steps onto its saturation value.
  assign w_line_sat    = ~w_hs_edge && (r_line_cnt == CNT_MAX - 10'd1);
  assign w_period_bad  = w_hs_edge && (w_line_period != H_TOTAL_W);
  assign w_frame_bad   = ({1'b0, r_fl_cnt} != V_TOTAL_W);

  // NOTE: every register, including the pixel pipeline, is cleared so the
  // outputs read 0 straight after reset rather than stale pixel data.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_hs_d        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_line_cnt    <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_fl_cnt      <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_ox          <= '0;
      r_oy          <= '0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_blank       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every counter see the same
      // pre-edge values, which is what makes oX/oY carry the pre-increment count.
      r_hs_d <= bus.iHS;
      r_vs_d <= bus.iVS;

      if (w_hs_edge) begin
        r_line_cnt <= '0;
        r_line_len <= (r_line_cnt == CNT_MAX) ? CNT_MAX : w_line_period[9:0];
      end else if (r_line_cnt != CNT_MAX) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end

      if (w_hs_edge)                       r_x <= '0;
      else if (bus.iBLANK && r_x != CNT_MAX) r_x <= r_x + 10'd1;

      // A non-zero x count means the line that just ended had visible pixels.
      if (w_vs_edge)                                         r_y <= '0;
      else if (w_hs_edge && r_x != '0 && r_y != CNT_MAX)     r_y <= r_y + 10'd1;

      if (w_vs_edge) begin
        r_frame_lines <= r_fl_cnt;
        r_fl_cnt      <= '0;
      end else if (w_hs_edge && r_fl_cnt != CNT_MAX) begin
        r_fl_cnt <= r_fl_cnt + 10'd1;
      end

      r_ox    <= r_x;
      r_oy    <= r_y;
      r_red   <= bus.iRed;
      r_green <= bus.iGreen;
      r_blue  <= bus.iBlue;
      r_blank <= bus.iBLANK;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state    <= S_SEARCH;
      r_good     <= '0;
      r_line_err <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good     <= w_good_next;
      r_line_err <= w_line_err_next;
      r_err      <= w_err_next;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_good_next     = r_good;
    w_line_err_next = r_line_err;
    w_err_next      = 1'b0;
    unique case (r_state)
      S_SEARCH: begin
        if (w_vs_edge) begin
          w_state_next    = S_MEASURE;
          w_good_next     = '0;
          w_line_err_next = 1'b0;
        end
      end
      S_MEASURE: begin
        if (w_period_bad) w_line_err_next = 1'b1;
        if (w_vs_edge) begin
          if (!r_line_err && !w_period_bad && !w_frame_bad) w_good_next = r_good + 3'd1;
          else                                             w_good_next = '0;
          w_line_err_next = 1'b0;
          if (w_good_next == LOCK_W) w_state_next = S_LOCKED;
        end
        if (w_line_sat) w_state_next = S_SEARCH;
      end
      S_LOCKED: begin
        if (w_period_bad || (w_vs_edge && w_frame_bad) || w_line_sat) begin
          w_err_next   = 1'b1;
          w_state_next = S_SEARCH;
        end
      end
      default: w_state_next = S_SEARCH;
    endcase
  end

  assign bus.oX          = r_ox;
  assign bus.oY          = r_oy;
  assign bus.oRed        = r_red;
  assign bus.oGreen      = r_green;
  assign bus.oBlue       = r_blue;
  assign bus.oLocked     = (r_state == S_LOCKED);
  assign bus.oValid      = r_blank & bus.oLocked;
  assign bus.oErr        = r_err;
  assign bus.oLineLen    = r_line_len;
  assign bus.oFrameLines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a short vector table for the counters, then whole
// frames on a scaled-down raster (100x20, 64x12 visible) so the run stays short.
module tb_vga_sync_decoder;

  localparam int H_TOT    = 100;
  localparam int HS_LEN   = 10;
  localparam int HV_START = 16;
  localparam int H_VIS    = 64;
  localparam int V_TOT    = 20;
  localparam int V_VIS    = 12;
  localparam int VS_LINE  = 14;
  localparam int VS_COL   = 50;

  typedef struct {
    logic       hs, vs, blank;
    logic [9:0] red;
    logic [9:0] x, y, ored, ll, fl;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   err_seen = 0;
  vec_t vq[$];

  vga_sync_decoder_if bus();

  vga_sync_decoder #(.H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .LOCK_FRAMES(2)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.oErr === 1'b1) err_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, return 1 time unit after it.
  task automatic cyc(input logic hs, input logic vs, input logic blank,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    bus.iHS = hs; bus.iVS = vs; bus.iBLANK = blank;
    bus.iRed = r; bus.iGreen = g; bus.iBlue = b;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic hs, input logic vs, input logic blank, input logic [9:0] red,
                     input logic [9:0] x, input logic [9:0] y, input logic [9:0] ored,
                     input logic [9:0] ll, input logic [9:0] fl);
    vec_t v;
    v.hs = hs; v.vs = vs; v.blank = blank; v.red = red;
    v.x = x; v.y = y; v.ored = ored; v.ll = ll; v.fl = fl;
    vq.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_xyr"}, {bus.oX, bus.oY, bus.oRed}, 64'd0);
    check({tag, "_gbl"}, {bus.oGreen, bus.oBlue, bus.oLineLen}, 64'd0);
    check({tag, "_flags"}, {bus.oFrameLines, bus.oValid, bus.oLocked, bus.oErr}, 64'd0);
  endtask

  task automatic run_frame(input int short_line, input int rst_line, input bit chk_px, input bit chk_lock);
    for (int l = 0; l < V_TOT; l++) begin
      int len;
      len = (l == short_line) ? H_TOT - 1 : H_TOT;
      for (int c = 0; c < len; c++) begin
        logic hs, vs, vis;
        logic [9:0] red;
        hs  = (c >= HS_LEN);
        vs  = !((l == VS_LINE && c >= VS_COL) || l == VS_LINE + 1 || (l == VS_LINE + 2 && c < VS_COL));
        vis = (l < V_VIS) && (c >= HV_START) && (c < HV_START + H_VIS);
        red = (l == 0 && c == HV_START) ? 10'h3FF : 10'(c);
        if (l == rst_line && c == 50) rst_n = 1'b0;
        if (chk_lock && l == VS_LINE && c == VS_COL) check("lock_before_vs", bus.oLocked, 0);
        cyc(hs, vs, vis, red, 10'h0, 10'h0);
        if (l == rst_line && c == 50) begin
          check_all_zero("midrst");
          rst_n = 1'b1;
        end
        if (chk_lock && l == VS_LINE && c == VS_COL) check("lock_at_vs", bus.oLocked, 1);
        if (chk_px && l == 0 && c == HV_START) begin
          check("first_px_xy", {bus.oX, bus.oY}, 0);
          check("first_px_valid", bus.oValid, 1);
          check("first_px_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, {10'h3FF, 10'h0, 10'h0});
        end
        if (chk_px && l == 0 && c == HV_START + H_VIS) check("blank_px_valid", bus.oValid, 0);
        if (chk_px && l == V_VIS - 1 && c == HV_START + H_VIS - 1) begin
          check("last_px_x", bus.oX, H_VIS - 1);
          check("last_px_y", bus.oY, V_VIS - 1);
          check("last_px_valid", bus.oValid, 1);
        end
        if (short_line >= 0 && l == short_line + 1 && c == 0) begin
          check("short_err", bus.oErr, 1);
          check("short_unlocked", bus.oLocked, 0);
        end
        if (short_line >= 0 && l == short_line + 1 && c == 1) check("short_err_gone", bus.oErr, 0);
      end
    end
  endtask

  initial begin
    int e0;
    int valid_bad;

    //   hs vs bl red      x  y  ored    ll fl
    add(1, 1, 1, 10'd5,    0, 0, 10'd5,  0, 0);
    add(1, 1, 1, 10'd6,    1, 0, 10'd6,  0, 0);
    add(0, 1, 0, 10'd7,    2, 0, 10'd7,  3, 0);
    add(1, 1, 1, 10'd8,    0, 1, 10'd8,  3, 0);
    add(1, 1, 0, 10'd9,    1, 1, 10'd9,  3, 0);
    add(1, 1, 0, 10'd10,   1, 1, 10'd10, 3, 0);
    add(0, 0, 0, 10'd11,   1, 1, 10'd11, 4, 1);   // HS and VS fall together
    add(1, 1, 1, 10'h3FF,  0, 0, 10'h3FF,4, 1);
    add(1, 1, 1, 10'd1,    1, 0, 10'd1,  4, 1);
    add(0, 1, 0, 10'd12,   2, 0, 10'd12, 3, 1);
    add(1, 1, 0, 10'd13,   0, 1, 10'd13, 3, 1);
    add(0, 1, 0, 10'd14,   0, 1, 10'd14, 2, 1);   // blank-only line: y holds
    add(1, 0, 1, 10'd2,    0, 1, 10'd2,  2, 2);
    add(1, 0, 1, 10'd3,    1, 0, 10'd3,  2, 2);

    bus.iHS = 1'b1; bus.iVS = 1'b1; bus.iBLANK = 1'b0;
    bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vq[i]) begin
      cyc(vq[i].hs, vq[i].vs, vq[i].blank, vq[i].red, 10'h0, 10'h0);
      check($sformatf("vec%0d_xy", i), {bus.oX, bus.oY}, {vq[i].x, vq[i].y});
      check($sformatf("vec%0d_red", i), bus.oRed, vq[i].ored);
      check($sformatf("vec%0d_len", i), {bus.oLineLen, bus.oFrameLines}, {vq[i].ll, vq[i].fl});
      check($sformatf("vec%0d_valid", i), bus.oValid, 0);
    end

    rst_n = 1'b0;
    cyc(1, 1, 0, 10'h0, 10'h0, 10'h0);
    rst_n = 1'b1;

    // Acquisition from reset: lock at the third VS edge.
    run_frame(-1, -1, 0, 0);
    run_frame(-1, -1, 0, 0);
    check("lock_after_2", bus.oLocked, 0);
    run_frame(-1, -1, 0, 1);
    check("lock_after_3", bus.oLocked, 1);
    check("line_len", bus.oLineLen, H_TOT);
    check("frame_lines", bus.oFrameLines, V_TOT);

    run_frame(-1, -1, 1, 0);
    check("still_locked", bus.oLocked, 1);

    // One short line drops lock; two clean frames after re-entering MEASURE relock.
    e0 = err_seen;
    run_frame(5, -1, 0, 0);
    check("short_err_count", err_seen - e0, 1);
    check("short_frame_unlocked", bus.oLocked, 0);
    run_frame(-1, -1, 0, 0);
    check("relock_1", bus.oLocked, 0);
    run_frame(-1, -1, 0, 0);
    check("relock_2", bus.oLocked, 1);

    // HS stuck high: counter was 99 entering the hold, hits 1023 after hold cycle 924.
    e0 = err_seen;
    valid_bad = 0;
    for (int k = 1; k <= 1100; k++) begin
      cyc(1, 1, 0, 10'h0, 10'h0, 10'h0);
      if (bus.oValid !== 1'b0) valid_bad++;
      if (k == 923) check("sat_pre", {bus.oErr, bus.oLocked}, 2'b01);
      if (k == 924) check("sat_err", {bus.oErr, bus.oLocked}, 2'b10);
      if (k == 925) check("sat_post", {bus.oErr, bus.oLocked}, 2'b00);
    end
    check("sat_err_count", err_seen - e0, 1);
    check("sat_valid_low", valid_bad, 0);
    run_frame(-1, -1, 0, 0);
    run_frame(-1, -1, 0, 0);
    run_frame(-1, -1, 0, 0);
    check("relock_after_sat", bus.oLocked, 1);

    // One-cycle reset mid-frame while locked.
    e0 = err_seen;
    run_frame(-1, 5, 0, 0);
    check("rst_frame_unlocked", bus.oLocked, 0);
    run_frame(-1, -1, 0, 0);
    check("rst_relock_1", bus.oLocked, 0);
    run_frame(-1, -1, 0, 0);
    check("rst_relock_2", bus.oLocked, 1);
    check("rst_no_err", err_seen - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 525, lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames to declare lock (1..7).
REQ-004 iCLK  in  1  pixel clock; all inputs are synchronous to it.
REQ-005 iRST_N  in  1  reset; synchronous, active-low.
REQ-006 iHS  in  1  horizontal sync, active-low.
REQ-007 iVS  in  1  vertical sync, active-low.
REQ-008 iBLANK  in  1  active-low blank; high = visible pixel.
REQ-009 iRed, iGreen, iBlue  in  10 each  pixel colour.
REQ-010 oX, oY  out  10 each  decoded pixel coordinates.
REQ-011 oRed, oGreen, oBlue  out  10 each  registered colour.
REQ-012 oValid  out  1  visible pixel and decoder locked.
REQ-013 oLocked  out  1  timing lock status.
REQ-014 oErr  out  1  one-cycle pulse on loss of lock.
REQ-015 oLineLen  out  10  last measured HS period in clocks.
REQ-016 oFrameLines  out  10  last measured lines per frame.

Function
REQ-017 HS/VS falling edges SHALL be detected against a one-cycle-delayed copy; an edge is flagged in the cycle the input is first seen low.
REQ-018 The line counter SHALL count clocks since the last HS edge, saturating at 1023; on an HS edge, its value +1 is loaded into oLineLen and the counter restarts at 0.
REQ-019 The x counter SHALL clear on an HS edge and increment on each cycle with iBLANK high, saturating at 1023.
REQ-020 The y counter SHALL increment on an HS edge only if the line just ended contained at least one visible pixel; it clears on a VS edge, saturating at 1023.
REQ-021 The frame line counter SHALL increment on each HS edge; on a VS edge its value is loaded into oFrameLines and it clears.
REQ-022 HS and VS edges in the same cycle: both SHALL be processed; VS clear wins over the y and frame-line increments, and the HS line closure still updates oLineLen.
REQ-023 oX, oY, oRed, oGreen, oBlue SHALL be registered with one-cycle latency from the corresponding input pixel; oX/oY carry the pre-increment x/y for that pixel.
REQ-024 oValid SHALL equal the registered iBLANK ANDed with oLocked, aligned with oX/oY.
REQ-025 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-026 SEARCH: on a VS edge go to MEASURE, good-frame count = 0, line-error flag cleared.
REQ-027 MEASURE: any HS edge with period != H_TOTAL sets the line-error flag; on a VS edge, if the flag is clear and frame lines == V_TOTAL, increment the good count, else set the good count to 0; clear the flag. When the good count reaches LOCK_FRAMES, go to LOCKED.
REQ-028 LOCKED: an HS period != H_TOTAL, a VS edge with frame lines != V_TOTAL, or the line counter saturating at 1023 SHALL pulse oErr for one cycle and go to SEARCH.
REQ-029 The line counter saturating in MEASURE SHALL return to SEARCH without an oErr pulse.
REQ-030 oLocked SHALL be high exactly while the state is LOCKED, registered.

Reset
REQ-031 With iRST_N low at a clock edge, all counters, oX, oY, colour outputs, oLineLen and oFrameLines SHALL be 0; oValid, oLocked and oErr SHALL be 0; the state SHALL be SEARCH; the edge-detect registers SHALL be 1.
REQ-032 Reset asserted mid-frame or mid-lock SHALL take effect on the next edge with no oErr pulse; the decoder re-acquires from SEARCH.

Verification
REQ-033 Three clean 640x480 frames (800x525, HS low 96, VS low 2) from reset -> oLocked rises at the VS edge ending frame 3 (MEASURE entered at first VS edge), oLineLen=800, oFrameLines=525.
REQ-034 While locked, the first visible pixel of a frame, with colour 10'h3FF/0/0 -> one cycle later oX=0, oY=0, oValid=1, oRed=10'h3FF; the last visible pixel gives oX=639, oY=479.
REQ-035 While locked, one line shortened to 799 clocks -> oErr high for exactly 1 cycle at that HS edge; oLocked=0 next cycle; relock after LOCK_FRAMES further clean frames.
REQ-036 HS held high for 1100 clocks while locked -> oErr pulse when the line counter hits 1023; state SEARCH; oValid=0 throughout.
REQ-037 HS and VS falling edges in the same cycle -> oY=0 on the next frame's first pixel, oFrameLines is not incremented by that HS, and oLineLen is updated.
REQ-038 iRST_N pulsed low for 1 cycle mid-frame while locked -> all outputs 0 next cycle, oErr never asserted, lock regained after LOCK_FRAMES clean frames.
